// File: rtl/cdc_arb_pkg.sv
// Shared types and defaults for the pulse arbiter in front of the req/ack CDC channel.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_HI  = 2'd1,
        WAIT_LO = 2'd2
    } arb_state_e;

    localparam int TMO_CYC_DEF = 64;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set-bit search: returns the first set index at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [ID_W-1:0]    ptr,
    output logic               vld,
    output logic [ID_W-1:0]    idx
);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W:0]      sum;

    always_comb begin
        vld = 1'b0;
        sum = '0;
        // Doubling the vector turns the wrap-around search into a plain rotate.
        rot = NUM_REQ'({req_vec, req_vec} >> ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!vld && rot[k]) begin
                vld = 1'b1;
                sum = {1'b0, ptr} + (ID_W+1)'(k);
            end
        end
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end
        idx = sum[ID_W-1:0];
    end

endmodule

// File: rtl/cdc_pulse_arbiter.sv
// Counts single-cycle request pulses per requester and serialises them round-robin
// onto one 4-phase req/ack CDC channel, with sticky overflow and handshake-timeout flags.
//
// state   | meaning
// IDLE    | no handshake in flight; grant next pending requester if any
// REQ_HI  | xfer_req high, waiting for ack to rise
// WAIT_LO | xfer_req low, waiting for ack to fall
module cdc_pulse_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic               clka,
    input  logic               rsta,
    input  logic [NUM_REQ-1:0] req_pulse,
    output logic               xfer_req,
    output logic [ID_W-1:0]    xfer_id,
    input  logic               xfer_ack,
    output logic               busy,
    output logic               pend_any,
    output logic [NUM_REQ-1:0] err_ovf,
    output logic               err_tmo
);

    localparam int TMR_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TMO_CYC);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic               xfer_req_q, xfer_req_d;
    logic [ID_W-1:0]    xfer_id_q, xfer_id_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               err_tmo_q, err_tmo_d;
    logic [NUM_REQ-1:0] err_ovf_q, err_ovf_d;
    logic [CNT_W-1:0]   pend_q [NUM_REQ];
    logic [CNT_W-1:0]   pend_d [NUM_REQ];

    logic [NUM_REQ-1:0] pend_nz;
    logic [NUM_REQ-1:0] dec_vec;
    logic               pick_vld;
    logic [ID_W-1:0]    pick_idx;
    logic               grant;

    always_comb begin
        pend_nz = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_nz[i] = (pend_q[i] != '0);
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_vec (pend_nz),
        .ptr     (rr_q),
        .vld     (pick_vld),
        .idx     (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        xfer_req_d = xfer_req_q;
        xfer_id_d  = xfer_id_q;
        grant      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant      = 1'b1;
                    state_d    = REQ_HI;
                    xfer_req_d = 1'b1;
                    xfer_id_d  = pick_idx;
                    rr_d       = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            REQ_HI: begin
                if (xfer_ack) begin
                    xfer_req_d = 1'b0;
                    state_d    = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!xfer_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                xfer_req_d = 1'b0;
            end
        endcase

        // Timeout only flags; the handshake itself is never abandoned.
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q != IDLE && timer_q != TMR_END) begin
            timer_d = timer_q + 1'b1;
        end
        err_tmo_d = err_tmo_q | (timer_d == TMR_END);
    end

    always_comb begin
        dec_vec   = '0;
        err_ovf_d = err_ovf_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            dec_vec[i] = grant && (pick_idx == ID_W'(i));
            pend_d[i]  = pend_q[i];
            if (req_pulse[i] && !dec_vec[i]) begin
                if (pend_q[i] == CNT_MAX) begin
                    err_ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 1'b1;
                end
            end else if (dec_vec[i] && !req_pulse[i]) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            xfer_req_q <= 1'b0;
            xfer_id_q  <= '0;
            timer_q    <= '0;
            err_tmo_q  <= 1'b0;
            err_ovf_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            xfer_req_q <= xfer_req_d;
            xfer_id_q  <= xfer_id_d;
            timer_q    <= timer_d;
            err_tmo_q  <= err_tmo_d;
            err_ovf_q  <= err_ovf_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign xfer_req = xfer_req_q;
    assign xfer_id  = xfer_id_q;
    assign busy     = (state_q != IDLE);
    assign pend_any = |pend_nz;
    assign err_ovf  = err_ovf_q;
    assign err_tmo  = err_tmo_q;

endmodule

// File: doc/cdc_pulse_arbiter.md
Name: cdc_pulse_arbiter

Overview:
Source-domain (clka) sequencer that shares one 4-phase req/ack CDC channel between NUM_REQ single-cycle pulse requesters.
- Each request pulse is counted.
- Pending requests are granted round-robin and presented as a level xfer_req plus xfer_id, which the downstream crossing carries into the slow clkb domain.
- No back-to-back fast pulses are lost across a fast-to-slow crossing; the block counts and spaces them.
- xfer_ack is already synchronised into clka by the crossing logic outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
CNT_W, 4, width of each per-requester pending counter
ID_W, $clog2(NUM_REQ), width of xfer_id
TMO_CYC, 64, clka cycles a handshake phase may last before err_tmo is set

Ports:
clka  in  1  clock
rsta  in  1  reset; synchronous, active-high
req_pulse  in  NUM_REQ  one-cycle request pulses, one bit per requester
xfer_req  out  1  level request to the CDC channel
xfer_id  out  ID_W  index of the granted requester; stable while xfer_req=1 and until ack falls
xfer_ack  in  1  synchronised ack level from the clkb side
busy  out  1  FSM not in IDLE
pend_any  out  1  OR of all nonzero pending counters
err_ovf  out  NUM_REQ  sticky; a pulse arrived while that counter was saturated
err_tmo  out  1  sticky; a handshake phase exceeded TMO_CYC cycles

Behaviour:
- Reset (rsta=1 at a clka edge):
  - Counters 0, FSM IDLE, rr pointer 0.
  - xfer_req=0, xfer_id=0, busy=0, err_ovf=0, err_tmo=0, timer 0.
  - Reset mid-handshake drops xfer_req immediately; the far side must also be reset.
- Pending counters:
  - pend[i] increments on req_pulse[i] and decrements on grant to i.
  - Pulse and grant on the same i in the same cycle: count unchanged.
  - At 2^CNT_W-1 the counter saturates; a further pulse with no same-cycle grant sets err_ovf[i].
- FSM states: IDLE, REQ_HI, WAIT_LO, plus a timeout timer.
  - IDLE, any pend nonzero: grant the first nonzero index at or after rr pointer (wrapping). Decrement that counter; register xfer_id=i, xfer_req=1; rr pointer := (i+1) mod NUM_REQ; go to REQ_HI.
  - IDLE, all pend zero: stay in IDLE.
  - REQ_HI: hold xfer_req=1 and xfer_id. On xfer_ack=1, set xfer_req=0 and go to WAIT_LO.
  - WAIT_LO: on xfer_ack=0, go to IDLE. The next grant is possible in that same IDLE cycle's evaluation, i.e. one cycle later.
  - xfer_ack=1 seen in IDLE is ignored (it is the previous ack still falling, which cannot happen by protocol); no transition.
- Latency:
  - req_pulse sampled at edge n; pend=1 after edge n.
  - Grant at edge n+1; xfer_req=1 after edge n+1.
  - Minimum grant-to-grant spacing is 2 cycles plus the ack round trip.
- Timer:
  - Clears on every state change and counts in REQ_HI and WAIT_LO.
  - Reaching TMO_CYC sets err_tmo and saturates the timer.
  - The handshake is never aborted; the FSM keeps waiting.
- Derived outputs: busy = (state != IDLE); pend_any is combinational from the counters.

Decomposition:
- Package cdc_arb_pkg: state enum (IDLE, REQ_HI, WAIT_LO) and the default TMO_CYC constant.
- Sub-module rr_pick: combinational round-robin first-set-bit search from the pointer, parameterised by NUM_REQ.
- Counters and FSM stay in the top module.

Test Plan:
- Single pulse: req_pulse=4'b0010 at cycle 5 -> xfer_req=1 from cycle 7 with xfer_id=1. Ack model raises ack 6 cycles later -> xfer_req drops the cycle after; ack falls -> busy=0, pend_any=0.
- Burst on one requester: 3 pulses on req 0 in consecutive cycles -> pend[0] peaks at 2 after the first grant. Exactly 3 handshakes with xfer_id=0, then idle.
- Round robin: pulses on reqs 0, 2, 3 in the same cycle -> grant order 0, 2, 3. Then a new pulse on 0 and 3 while 3 is active -> grant order 0, 3.
- Simultaneous pulse and grant: req_pulse[1] in the same cycle req 1 is granted with pend[1]=1 -> pend[1] stays 1 and a second handshake follows.
- Overflow: 17 pulses on req 2 with ack held low (CNT_W=4) -> pend[2] saturates at 15 after the first grant. err_ovf=4'b0100 only; reset clears it.
- Timeout and reset: ack never rises -> err_tmo=1 at 64 cycles after entering REQ_HI, xfer_req still 1. Assert rsta for 1 cycle -> xfer_req=0, err_tmo=0, busy=0 on the next cycle.
